// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser deserialiser.
// Holds the output-side state encoding and the bit-counter width function.
package sipo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register plus bit counter; presents the assembled word and a
// single-cycle word_done strobe in the cycle the final bit is being sampled.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d,
  input  logic                    d_en,
  input  logic                    frame_clr,
  output logic [WIDTH-1:0]        sr,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]        word,
  output logic                    word_done
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic shift_en;

  // frame_clr wins over d_en: the bit offered in a clearing cycle is dropped.
  assign shift_en = d_en && !frame_clr;

  // word is the would-be sr after this shift, so it already includes d.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word = {sr[WIDTH-2:0], d};
    end else begin : g_lsb
      assign word = {d, sr[WIDTH-1:1]};
    end
  endgenerate

  assign word_done = shift_en && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (frame_clr || word_done) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr      <= word;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser: shift core plus a held output word with
// valid/ready handoff and a sticky overrun flag for words dropped while full.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d,
  input  logic                    d_en,
  input  logic                    frame_clr,
  input  logic                    q_ready,
  input  logic                    ovr_clr,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [WIDTH-1:0]        sr,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt,
  output logic                    overrun
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic [WIDTH-1:0] q_d;
  logic             ovr_set;
  out_state_e       state_q;
  out_state_e       state_d;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .d_en      (d_en),
    .frame_clr (frame_clr),
    .sr        (sr),
    .bit_cnt   (bit_cnt),
    .word      (word),
    .word_done (word_done)
  );

  // Handshake: a word transfers at any edge where q_valid=1 and q_ready=1;
  // q is held stable while q_valid=1 and q_ready=0, and q_ready is a no-op
  // while q_valid=0. q_valid is the decoded output state, never a raw input.
  always_comb begin
    state_d = state_q;
    q_d     = q;
    ovr_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (word_done) begin
          state_d = FULL;
          q_d     = word;
        end
      end
      FULL: begin
        if (word_done) begin
          if (q_ready) q_d = word;
          else         ovr_set = 1'b1;
        end else if (q_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      q       <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      q       <= q_d;
      // A new drop in the same cycle as ovr_clr keeps the flag set.
      overrun <= ovr_set || (overrun && !ovr_clr);
    end
  end

  assign q_valid = (state_q == FULL);

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: two instances (MSB-first and LSB-first) share stimulus;
// a bit-list reference model feeds expected-word queues popped by a monitor.
module tb_sipo_deser;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             d = 1'b0;
  logic             d_en = 1'b0;
  logic             frame_clr = 1'b0;
  logic             q_ready = 1'b0;
  logic             ovr_clr = 1'b0;

  logic [WIDTH-1:0] q_m, sr_m, q_l, sr_l;
  logic [2:0]       bit_cnt_m, bit_cnt_l;
  logic             q_valid_m, overrun_m, q_valid_l, overrun_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic             bit_q[$];
  logic [WIDTH-1:0] exp_q_m[$];
  logic [WIDTH-1:0] exp_q_l[$];
  logic             m_full = 1'b0;
  logic             m_ovr = 1'b0;
  logic [WIDTH-1:0] m_q_m = '0;
  logic [WIDTH-1:0] m_q_l = '0;

  // Monitor history
  logic pv_m = 1'b0;
  logic pv_l = 1'b0;
  logic pr   = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .d(d), .d_en(d_en), .frame_clr(frame_clr),
    .q_ready(q_ready), .ovr_clr(ovr_clr), .q(q_m), .q_valid(q_valid_m),
    .sr(sr_m), .bit_cnt(bit_cnt_m), .overrun(overrun_m)
  );

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .d(d), .d_en(d_en), .frame_clr(frame_clr),
    .q_ready(q_ready), .ovr_clr(ovr_clr), .q(q_l), .q_valid(q_valid_l),
    .sr(sr_l), .bit_cnt(bit_cnt_l), .overrun(overrun_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word value from a complete bit list: first bit is MSB or LSB.
  function automatic logic [WIDTH-1:0] word_of(input bit msb_first);
    logic [WIDTH-1:0] w = '0;
    for (int i = 0; i < bit_q.size(); i++)
      if (bit_q[i]) w = w + (msb_first ? (WIDTH'(1) << (WIDTH - 1 - i)) : (WIDTH'(1) << i));
    return w;
  endfunction

  // Partial-word register image after n = bit_q.size() bits.
  function automatic logic [WIDTH-1:0] sr_of(input bit msb_first);
    logic [WIDTH-1:0] w = '0;
    int n = bit_q.size();
    for (int i = 0; i < n; i++)
      if (bit_q[i]) w = w + (msb_first ? (WIDTH'(1) << (n - 1 - i)) : (WIDTH'(1) << (WIDTH - n + i)));
    return w;
  endfunction

  task automatic model_edge(input logic d_i, input logic en_i, input logic fc_i,
                            input logic rdy_i, input logic oc_i, input logic rst_i);
    logic             done;
    logic             set_ovr;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] wl;
    done = 1'b0;
    set_ovr = 1'b0;
    wm = '0;
    wl = '0;
    if (!rst_i) begin
      bit_q.delete();
      m_full = 1'b0;
      m_ovr  = 1'b0;
      m_q_m  = '0;
      m_q_l  = '0;
    end else begin
      if (fc_i) begin
        bit_q.delete();
      end else if (en_i) begin
        bit_q.push_back(d_i);
        if (bit_q.size() == WIDTH) begin
          done = 1'b1;
          wm = word_of(1'b1);
          wl = word_of(1'b0);
          bit_q.delete();
        end
      end
      if (done) begin
        if (!m_full || rdy_i) begin
          m_full = 1'b1;
          m_q_m = wm;
          m_q_l = wl;
          exp_q_m.push_back(wm);
          exp_q_l.push_back(wl);
        end else begin
          set_ovr = 1'b1;
        end
      end else if (m_full && rdy_i) begin
        m_full = 1'b0;
      end
      if (set_ovr)   m_ovr = 1'b1;
      else if (oc_i) m_ovr = 1'b0;
    end
  endtask

  task automatic check_state();
    chk("bit_cnt_m", bit_cnt_m, bit_q.size());
    chk("bit_cnt_l", bit_cnt_l, bit_q.size());
    chk("sr_m", sr_m, sr_of(1'b1));
    chk("sr_l", sr_l, sr_of(1'b0));
    chk("q_valid_m", q_valid_m, m_full);
    chk("q_valid_l", q_valid_l, m_full);
    chk("q_m", q_m, m_q_m);
    chk("q_l", q_l, m_q_l);
    chk("overrun_m", overrun_m, m_ovr);
    chk("overrun_l", overrun_l, m_ovr);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic d_i, input logic en_i, input logic fc_i,
                      input logic rdy_i, input logic oc_i, input logic rst_i);
    rst_n = rst_i;
    d = d_i;
    d_en = en_i;
    frame_clr = fc_i;
    q_ready = rdy_i;
    ovr_clr = oc_i;
    @(posedge clk);
    #1;
    model_edge(d_i, en_i, fc_i, rdy_i, oc_i, rst_i);
    check_state();
  endtask

  task automatic idle(input logic rdy_i);
    step(1'b0, 1'b0, 1'b0, rdy_i, 1'b0, 1'b1);
  endtask

  // Sends v first-bit = v[WIDTH-1]; q_ready/ovr_clr on the last bit may differ.
  task automatic send_word(input logic [WIDTH-1:0] v, input logic rdy_body,
                           input logic rdy_last, input logic oc_last);
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) step(v[WIDTH-1-i], 1'b1, 1'b0, rdy_last, oc_last, 1'b1);
      else                step(v[WIDTH-1-i], 1'b1, 1'b0, rdy_body, 1'b0, 1'b1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // A fresh word is presented when q_valid is high after an edge that either
  // found the output empty or completed a handshake.
  always @(negedge clk) begin
    if (q_valid_m === 1'b1 && (!pv_m || pr)) begin
      if (exp_q_m.size() == 0) chk("sb_m_unexpected", q_m, 32'hFFFF_FFFF);
      else                     chk("sb_m_word", q_m, exp_q_m.pop_front());
    end
    if (q_valid_l === 1'b1 && (!pv_l || pr)) begin
      if (exp_q_l.size() == 0) chk("sb_l_unexpected", q_l, 32'hFFFF_FFFF);
      else                     chk("sb_l_word", q_l, exp_q_l.pop_front());
    end
    pv_m = (q_valid_m === 1'b1);
    pv_l = (q_valid_l === 1'b1);
    pr   = (q_ready === 1'b1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [WIDTH-1:0] pat;

    // Reset: every output zero.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_q", q_m, 8'h00);

    // Bit order, continuous d_en, q_ready=1.
    send_word(8'hB2, 1'b1, 1'b1, 1'b0);
    chk("order_msb", q_m, 8'hB2);
    chk("order_lsb", q_l, 8'h4D);
    idle(1'b1);
    chk("order_valid_one_cycle", q_valid_m, 1'b0);

    // Gapped d_en.
    pat = 8'hB2;
    for (int i = 0; i < WIDTH; i++) begin
      step(pat[WIDTH-1-i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    chk("gapped_q", q_m, 8'hB2);

    // Back-pressure and overrun.
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_q", q_m, 8'hA5);
    chk("bp_overrun", overrun_m, 1'b1);
    idle(1'b1);
    chk("bp_valid_drop", q_valid_m, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_clr", overrun_m, 1'b0);

    // Overrun set and ovr_clr in the same cycle: set wins.
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", overrun_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Back-to-back transfer.
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("b2b_q", q_m, 8'h3C);
    chk("b2b_valid", q_valid_m, 1'b1);
    chk("b2b_overrun", overrun_m, 1'b0);

    // Frame clear after 5 bits, with d_en=1 on the clearing cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fclr_bit_cnt", bit_cnt_m, 3'd0);
    chk("fclr_sr", sr_m, 8'h00);
    chk("fclr_q_held", q_m, 8'h3C);
    idle(1'b1);
    send_word(8'hFF, 1'b1, 1'b1, 1'b0);
    chk("fclr_next_word", q_m, 8'hFF);

    // Reset mid-operation with a held word and 3 bits in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_valid", q_valid_m, 1'b0);
    chk("rst_mid_sr", sr_l, 8'h00);
    send_word(8'h81, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_fresh", q_m, 8'h81);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 299) != 0));
    end

    // Drain and confirm every expected word was presented.
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    #1;
    chk("sb_m_drained", exp_q_m.size(), 0);
    chk("sb_l_drained", exp_q_l.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser, the successor to the basic SIPO shift register. It assembles WIDTH-bit words from a qualified serial bit stream in either bit order. Each completed word is presented on a held output register with a valid/ready handshake, so downstream logic can stall without corrupting the word being shifted. It also flags words dropped because the output was still occupied.

## Interface
- WIDTH, 8: word width in bits, ≥ 2.
- MSB_FIRST, 1: 1 means the first received bit lands in q[WIDTH-1]; 0 means it lands in q[0].
- clk  in  1  single clock; everything updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- d  in  1  serial data bit.
- d_en  in  1  d is sampled only in cycles where d_en=1.
- frame_clr  in  1  restarts word assembly.
- q_ready  in  1  downstream accepts q this cycle.
- ovr_clr  in  1  clears the overrun flag.
- q  out  WIDTH  held parallel word.
- q_valid  out  1  q holds an unconsumed word.
- sr  out  WIDTH  live shift-register contents (debug/legacy tap).
- bit_cnt  out  $clog2(WIDTH)  bits collected in the current word.
- overrun  out  1  sticky flag: a completed word was dropped.

## Operation
- Reset (rst_n=0 at an edge) sets q, sr, bit_cnt, q_valid and overrun to 0. Reset overrides every other input.
- Shift, when d_en=1 and frame_clr=0:
  - MSB_FIRST=1: sr ← {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr ← {d, sr[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion: a shift with bit_cnt=WIDTH-1 completes the word.
  - bit_cnt wraps to 0 and sr ← 0.
  - The assembled word (sr with d included) is the candidate for q.
- Output side is a two-state machine, EMPTY (q_valid=0) and FULL (q_valid=1).
  - EMPTY + completion → FULL, q ← word.
  - FULL + q_ready, no completion → EMPTY; q keeps its last value.
  - FULL + q_ready + completion → stays FULL, q ← new word. Back-to-back transfer, no bubble.
  - FULL + !q_ready + completion → new word discarded, q unchanged, overrun ← 1.
  - q_ready while EMPTY has no effect.
- frame_clr=1 sets sr ← 0 and bit_cnt ← 0.
  - It has priority over d_en in the same cycle; that bit is discarded.
  - It does not touch q, q_valid or overrun.
- overrun: ovr_clr=1 clears it. If ovr_clr and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- d is ignored when d_en=0; all state holds.

## Timing
- Latency: the last bit is sampled at edge N, and q/q_valid are updated at edge N (registered outputs, visible right after that edge).
- A handshake completes at any edge where q_valid=1 and q_ready=1.
- q stays stable while q_valid=1 and q_ready=0.
- Sustained throughput is one word per WIDTH d_en cycles, with no dead cycle between words.
- sr and bit_cnt reflect the post-edge state.
- Reset mid-word discards the partial word and any held word.
- No combinational path from any input to any output.

## Structure
- Shared package sipo_pkg holds:
  - the output state enum {EMPTY, FULL};
  - a function cnt_w(WIDTH) = $clog2(WIDTH), used for the bit_cnt width.
- Sub-module sipo_shift_core: the parametrised shift register plus bit counter. It outputs the word and a one-cycle word_done pulse.
- The top level adds the output register, the handshake state machine and the overrun logic.
- Expected size: roughly 150–250 lines total.

## Test plan
- Bit order, MSB_FIRST=1, WIDTH=8, q_ready=1: serial 1,0,1,1,0,0,1,0 with d_en=1 every cycle → q=8'hB2, q_valid high for exactly one cycle at the 8th edge. Repeat with MSB_FIRST=0 → q=8'h4D.
- Gapped d_en: same 8 bits with d_en toggling 1,0 → q=8'hB2 after 16 cycles. bit_cnt steps 0..7 and holds during gaps.
- Back-pressure and overrun: q_ready=0, send 8'hA5 then 8'h3C → q stays 8'hA5, overrun=1 after the second word. Raise q_ready → q_valid drops. Pulse ovr_clr → overrun=0.
- Back-to-back transfer: q_ready=1 on the exact cycle the second word completes → q=8'h3C, q_valid stays 1, overrun stays 0.
- Frame clear: after 5 bits, assert frame_clr with d_en=1 → bit_cnt=0, sr=0, held q unchanged. The next 8 bits 0xFF → q=8'hFF.
- Reset mid-operation: rst_n=0 for one edge with 3 bits in sr and q_valid=1 → every output 0 after that edge. A fresh word of 8'h81 then assembles correctly.
